// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: push side, status and UART TX handshake of the transmit queue.
interface uart_tx_queue_if #(parameter int ADDR_W = 4);
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [ADDR_W:0] count;
  logic          overflow;
  logic          clr_overflow;
  logic [7:0]    uart_TX;
  logic          uart_en_TX;
  logic          uart_TX_ready;
  modport master (
    output wr_data, wr_en, clr_overflow, uart_TX_ready,
    input  full, empty, count, overflow, uart_TX, uart_en_TX
  );
  modport slave (
    input  wr_data, wr_en, clr_overflow, uart_TX_ready,
    output full, empty, count, overflow, uart_TX, uart_en_TX
  );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO draining into the UART TX/en_TX/TX_ready handshake, one en_TX pulse per byte.
// Define UART_TXQ_STATS_EN to add the 16-bit sent_count output.
module uart_tx_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic rst,
  uart_tx_queue_if.slave q
`ifdef UART_TXQ_STATS_EN
  ,
  output logic [15:0] sent_count
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        tx_q, tx_d;
  logic [1:0]        wait_q, wait_d;
  logic [7:0]        mem [DEPTH];
  logic              full, empty, wr_ok, pop;
  assign full  = count_q == (ADDR_W+1)'(DEPTH);
  assign empty = count_q == '0;
  assign wr_ok = q.wr_en && !full;
  assign pop   = state_q == ISSUE;
  assign q.full       = full;
  assign q.empty      = empty;
  assign q.count      = count_q;
  assign q.overflow   = ovf_q;
  assign q.uart_TX    = tx_q;
  assign q.uart_en_TX = state_q == ISSUE;
  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
    // A dropped write beats a same-cycle clear
    ovf_d    = (q.wr_en && full) ? 1'b1 : q.clr_overflow ? 1'b0 : ovf_q;
  end
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: if (!empty && q.uart_TX_ready) begin
        state_d = ISSUE;
        tx_d    = mem[rd_ptr_q];
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        wait_d  = '0;
      end
      // Give up after 4 cycles without the UART dropping ready; the byte is not re-issued
      WAIT_ACK: if (!q.uart_TX_ready) state_d = WAIT_DONE;
        else if (wait_q == 2'd3) state_d = IDLE;
        else wait_d = wait_q + 1'b1;
      default: state_d = q.uart_TX_ready ? IDLE : WAIT_DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tx_q     <= 8'd0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      wait_q   <= wait_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= q.wr_data;
  end
`ifdef UART_TXQ_STATS_EN
  logic [15:0] sent_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sent_q <= '0;
    else if (pop) sent_q <= sent_q + 16'd1;
  end
  assign sent_count = sent_q;
`endif
endmodule
